// File: rtl/wm_pkg.sv
// Shared types and widths for the washing-machine controller (wm_top, wm_timer).
package wm_pkg;

    localparam int STATE_W = 3;
    localparam int TIMER_W = 4;

    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF     = 3'b000,
        ST_FILL    = 3'b001,
        ST_WASH    = 3'b010,
        ST_DRAIN   = 3'b011,
        ST_RINSE   = 3'b100,
        ST_SPIN    = 3'b101,
        ST_DONE    = 3'b110,
        ST_ILLEGAL = 3'b111
    } state_t;

    // Timed phases are the contiguous encodings FillWater..Spin.
    function automatic logic is_timed(input state_t s);
        return (s >= ST_FILL) && (s <= ST_SPIN);
    endfunction

endpackage

// File: rtl/wm_timer.sv
// Phase timer: counts enabled cycles, clears on request, saturates at TIMER_MAX.
module wm_timer
    import wm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    output logic [TIMER_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TIMER_MAX)) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/wm_top.sv
// Washing-machine sequencer: Off -> Fill -> Wash -> Drain -> Rinse -> Spin -> Done -> Off.
// Define WM_STATE_OUT_EN to add the state_out port exposing the current state.
module wm_top
    import wm_pkg::*;
#(
    parameter int FILL_CYCLES  = 5,
    parameter int WASH_CYCLES  = 15,
    parameter int DRAIN_CYCLES = 5,
    parameter int RINSE_CYCLES = 10,
    parameter int SPIN_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_button,
    input  logic       pause_button,
    output logic       out
`ifdef WM_STATE_OUT_EN
    ,
    output logic [2:0] state_out
`endif
);

    // Last counter value of each phase; expiry happens on the edge that sees it.
    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_CYCLES - 1);

    state_t             state_q;
    state_t             next_state;
    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] last;
    logic               timed;
    logic               enable;
    logic               expire;
    logic               clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OFF;
            out     <= 1'b0;
        end else begin
            state_q <= next_state;
            out     <= (next_state == ST_DONE);
        end
    end

    always_comb begin
        next_state = state_q;
        last       = '0;
        timed      = is_timed(state_q);
        enable     = timed && !pause_button;

        case (state_q)
            ST_FILL:  last = FILL_LAST;
            ST_WASH:  last = WASH_LAST;
            ST_DRAIN: last = DRAIN_LAST;
            ST_RINSE: last = RINSE_LAST;
            ST_SPIN:  last = SPIN_LAST;
            default:  last = '0;
        endcase

        expire = enable && (count == last);

        case (state_q)
            ST_OFF:   if (start_button && !pause_button) next_state = ST_FILL;
            ST_FILL:  if (expire) next_state = ST_WASH;
            ST_WASH:  if (expire) next_state = ST_DRAIN;
            ST_DRAIN: if (expire) next_state = ST_RINSE;
            ST_RINSE: if (expire) next_state = ST_SPIN;
            ST_SPIN:  if (expire) next_state = ST_DONE;
            ST_DONE:  next_state = ST_OFF;
            default:  next_state = ST_OFF;
        endcase

        // Every phase starts counting from zero; Off/Done keep the timer parked.
        clear = (next_state != state_q) || !timed;
    end

    wm_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .count  (count)
    );

`ifdef WM_STATE_OUT_EN
    assign state_out = state_q;
`endif

endmodule

// File: tb/tb_wm_top.sv
// Bench for wm_top: constant vector table, hand-written corner sequences, and
// random start/pause/reset traffic checked against a phase/elapsed-time model.
module tb_wm_top;

    logic       clk_tb;
    logic       reset;
    logic       start_button;
    logic       pause_button;
    logic       out;
`ifdef WM_STATE_OUT_EN
    logic [2:0] state_out;
`endif

    int total = 0;
    int bad   = 0;

    wm_top dut (
        .clk          (clk_tb),
        .reset        (reset),
        .start_button (start_button),
        .pause_button (pause_button),
        .out          (out)
`ifdef WM_STATE_OUT_EN
        ,
        .state_out    (state_out)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Phase index follows the program order (0=Off, 1..5 timed, 6=Done);
    // elapsed counts unpaused cycles spent in the current phase.
    int m_phase   = 0;
    int m_elapsed = 0;
    int dur[7]    = '{0, 5, 15, 5, 10, 10, 0};

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
    endtask

    task automatic model_edge(input logic s, input logic p);
        if (m_phase == 0) begin
            if (s && !p) m_phase = 1;
        end else if (m_phase == 6) begin
            m_phase = 0;
        end else if (!p) begin
            m_elapsed++;
            if (m_elapsed == dur[m_phase]) begin
                m_phase++;
                m_elapsed = 0;
            end
        end
    endtask

    function automatic logic [7:0] model_word();
        logic [2:0] st;
        logic [3:0] cn;
        st = 3'(m_phase);
        cn = 4'(m_elapsed);
        return {st, cn, (m_phase == 6)};
    endfunction

    function automatic logic [7:0] dut_word();
        logic [2:0] st;
        st = dut.state_q;
        return {st, dut.count, out};
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives inputs, advances one edge, compares {state,count,out}.
    task automatic step(input logic s, input logic p, input string name);
        start_button = s;
        pause_button = p;
        model_edge(s, p);
        exp_q.push_back(model_word());
        @(posedge clk_tb);
        #1;
        check(name, {24'd0, dut_word()}, {24'd0, exp_q.pop_front()});
    endtask

    // Asynchronous reset pulse between edges; returns at posedge+1 in Off.
    task automatic pulse_reset(input string name);
        #2;
        reset = 1'b0;
        #1;
        check({name, "_state"}, {29'd0, dut.state_q}, 32'd0);
        check({name, "_count"}, {28'd0, dut.count}, 32'd0);
        check({name, "_out"},   {31'd0, out}, 32'd0);
        start_button = 1'b0;
        pause_button = 1'b0;
        model_reset();
        @(negedge clk_tb);
        reset = 1'b1;
        @(posedge clk_tb);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       s;
        logic       p;
        logic [2:0] st;
        logic [3:0] cnt;
        logic       o;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [2:0] st_now;
        logic [2:0] st_prev;
        int         chg[$];
        int         exp_edges[8] = '{1, 6, 21, 26, 36, 46, 47, 48};
        int         out_cycles;
        int         n;

        vt[0]  = '{1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 3'd0, 4'd0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'd1, 4'd0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 3'd1, 4'd1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 3'd1, 4'd1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 3'd1, 4'd1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 3'd1, 4'd2, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 3'd1, 4'd3, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 3'd1, 4'd4, 1'b0};
        vt[10] = '{1'b1, 1'b0, 3'd2, 4'd0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 3'd2, 4'd1, 1'b0};

        reset        = 1'b0;
        start_button = 1'b0;
        pause_button = 1'b0;
        #3;
        check("reset_state", {29'd0, dut.state_q}, 32'd0);
        check("reset_count", {28'd0, dut.count}, 32'd0);
        check("reset_out",   {31'd0, out}, 32'd0);
        repeat (2) @(negedge clk_tb);
        reset = 1'b1;
        @(posedge clk_tb);
        #1;

        // Idle after reset: ten edges with start low stay in Off.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "idle_off");
        check("idle_state_const", {29'd0, dut.state_q}, 32'd0);

        // Table: start while paused ignored, pause holds, start ignored in Fill/Wash.
        for (int i = 0; i < 12; i++) begin
            start_button = vt[i].s;
            pause_button = vt[i].p;
            @(posedge clk_tb);
            #1;
            check($sformatf("vec%0d", i), {24'd0, dut_word()},
                  {24'd0, vt[i].st, vt[i].cnt, vt[i].o});
        end

        // Full default program with start held high: state change edges.
        pulse_reset("rst_a");
        st_prev    = 3'd0;
        out_cycles = 0;
        for (int e = 1; e <= 48; e++) begin
            step(1'b1, 1'b0, "full_run");
            st_now = dut.state_q;
            if (st_now != st_prev) chg.push_back(e);
            if (out) out_cycles++;
            st_prev = st_now;
        end
        check("full_run_nchg", chg.size(), 32'd8);
        for (int i = 0; i < 8 && i < chg.size(); i++)
            check($sformatf("full_run_edge%0d", i), chg[i], exp_edges[i]);
        check("full_run_out_cycles", out_cycles, 32'd1);

        // Pause for six cycles in Wash at count 7, then eight more edges finish Wash.
        pulse_reset("rst_b");
        step(1'b1, 1'b0, "pz_start");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "pz_fill");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, "pz_wash");
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, "pz_hold");
            check("pz_hold_state", {29'd0, dut.state_q}, 32'd2);
            check("pz_hold_count", {28'd0, dut.count}, 32'd7);
        end
        n = 0;
        while (n < 20 && dut.state_q == 3'd2) begin
            step(1'b0, 1'b0, "pz_resume");
            n++;
        end
        check("pz_resume_edges", n, 32'd8);
        check("pz_after_state", {29'd0, dut.state_q}, 32'd3);

        // Reset mid-Rinse aborts; machine waits in Off until start.
        pulse_reset("rst_c");
        for (int i = 0; i < 29; i++) step(1'b1, 1'b0, "rinse_run");
        check("rinse_reached", {29'd0, dut.state_q}, 32'd4);
        pulse_reset("rinse_abort");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "abort_idle");
        check("abort_idle_state", {29'd0, dut.state_q}, 32'd0);
        step(1'b1, 1'b0, "abort_restart");
        check("abort_restart_state", {29'd0, dut.state_q}, 32'd1);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, "rnd");
                total++;
                if (out !== (dut.state_q == 3'd6)) begin
                    bad++;
                    $display("FAIL rnd_out_decode: got out=%0b expected %0b", out, dut.state_q == 3'd6);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
